// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Contents:
//   arb_state_e      - controller states (idle / transaction in flight)
//   PORT_IF, PORT_D  - requester ids; also the bit positions in the one-hot grant
//   MEM_LATENCY_MIN/MAX - legal range of the memory read latency
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int unsigned MEM_LATENCY_MIN = 1;
    localparam int unsigned MEM_LATENCY_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory port used by mem_port_arbiter.
// Modports:
//   slave  - the arbiter's view: requests and mem_rdata in; grants, responses and
//            memory strobes out
//   master - the environment's view (IFU, LSU and memory model): the mirror image
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import mem_arb_pkg::*;

    // Fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
// Ports:
//   i_req[1:0]     - pending requests, indexed by port id
//   i_last_winner  - port id granted most recently
//   o_gnt[1:0]     - one-hot grant (all zero when nothing is requested)
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_winner,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        // Contested: the port that did not win last time goes next.
        if (i_req == 2'b11) begin
            o_gnt = (i_last_winner == PORT_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch unit and the
// load/store path. One transaction at a time; the grant, mem_en and address are
// issued combinationally in IDLE, and the winner's rvalid pulses one cycle after
// the memory data is captured.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset; also masks grants while low
//   bus      - fetch, data and memory signals (slave modport)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mem_port_arbiter_if.slave       bus
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_lat_check
        $error("mem_port_arbiter: MEM_LATENCY out of range");
    end

    arb_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last_winner;
    logic              r_cur_port;
    logic              r_cur_we;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              w_mem_en;

    // Masking with reset_n keeps grants low even though requests are live in reset.
    assign w_req = {bus.d_req, bus.if_req} & {2{reset_n}};

    rr_arbiter2 u_rr (
        .i_req         (w_req),
        .i_last_winner (r_last_winner),
        .o_gnt         (w_pick)
    );

    assign w_gnt    = (r_state == ARB_IDLE) ? w_pick : 2'b00;
    assign w_mem_en = |w_gnt;

    always_comb begin
        bus.if_gnt    = w_gnt[PORT_IF];
        bus.d_gnt     = w_gnt[PORT_D];
        bus.mem_en    = w_mem_en;
        bus.mem_we    = w_gnt[PORT_D] & bus.d_we;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        if (w_gnt[PORT_D]) begin
            bus.mem_addr = bus.d_addr;
            if (bus.d_we) begin
                bus.mem_wdata = bus.d_wdata;
            end
        end else if (w_gnt[PORT_IF]) begin
            bus.mem_addr = bus.if_addr;
        end
    end

    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_rdata   = r_d_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ARB_IDLE;
            r_cnt         <= '0;
            r_last_winner <= PORT_D;
            r_cur_port    <= PORT_IF;
            r_cur_we      <= 1'b0;
            r_if_rvalid   <= 1'b0;
            r_d_rvalid    <= 1'b0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_mem_en) begin
                        r_state       <= ARB_BUSY;
                        r_cnt         <= CNT_W'(MEM_LATENCY);
                        r_last_winner <= w_gnt[PORT_D];
                        r_cur_port    <= w_gnt[PORT_D];
                        r_cur_we      <= w_gnt[PORT_D] & bus.d_we;
                    end
                end
                ARB_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Count of 1 here means mem_rdata is valid this cycle.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ARB_IDLE;
                        if (r_cur_port == PORT_D) begin
                            r_d_rvalid <= 1'b1;
                            if (!r_cur_we) begin
                                r_d_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.mem_rdata;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester controller that shares the single-port instruction/data memory between the instruction fetch unit and the load/store datapath. It arbitrates round-robin, sequences one fixed-latency memory transaction at a time and returns read data or write completion to the winning requester. It sits between the IFU, the data-memory access stage and the memory model.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15

- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch read request, held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted, 1-cycle pulse
- `if_rvalid`  out  1  fetch data valid, 1-cycle pulse
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request, held until `d_gnt`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_gnt`  out  1  data request accepted, 1-cycle pulse
- `d_rvalid`  out  1  read data valid or write complete, 1-cycle pulse
- `d_rdata`  out  DATA_W  data read data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid `MEM_LATENCY` cycles after `mem_en`

## Operation
- FSM has two states:
  - IDLE: arbitrate on current `if_req`/`d_req`.
  - BUSY: count down `MEM_LATENCY`.
- IDLE with no request: stay in IDLE; all strobes 0.
- IDLE with one or both requests:
  - Pick a winner.
  - In the same cycle, combinationally assert winner's `gnt`, `mem_en` and `mem_addr` from the winner's address.
  - `mem_we` = `d_we` for a data winner, 0 for fetch. `mem_wdata` = `d_wdata` for a data write, else 0.
  - Load counter with `MEM_LATENCY`; go to BUSY.
- Winner selection:
  - One request pending: it wins.
  - Both pending: the port not granted last wins (round-robin).
  - `last_winner` updates to the winner on every grant; reset value = data, so fetch wins the first contested grant after reset.
- BUSY:
  - Decrement counter each cycle.
  - On the cycle the counter reaches 0 (`mem_rdata` valid), register the result and return to IDLE.
- Response:
  - One cycle after BUSY ends, pulse the winner's `rvalid`.
  - Fetch and data reads: `rdata` captures `mem_rdata`.
  - Data writes: `d_rdata` unchanged.
  - `rdata` outputs hold until the next read completion on the same port.
- Requests are not latched. A request dropped before `gnt` is lost. Requests during BUSY are ignored until IDLE.
- While `reset_n` is low, `gnt` and `mem_en` are forced 0 regardless of requests.
- Reset mid-transaction:
  - State → IDLE, counter → 0, `last_winner` → data.
  - In-flight transaction is abandoned: no `rvalid` is ever issued for it.
- Counter width: `$clog2(MEM_LATENCY+1)`.

## Timing
- Grant and `mem_en` are asserted in cycle T (IDLE, combinational from `req`).
- `mem_rdata` is sampled at the end of cycle T+`MEM_LATENCY`.
- `rvalid` is asserted in cycle T+`MEM_LATENCY`+1; the FSM is IDLE in that cycle, so a new grant can be issued in the same cycle.
- Throughput: one transaction per `MEM_LATENCY`+1 cycles.
- Reset values: all outputs 0, `if_rdata` = `d_rdata` = 0, state IDLE.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `ARB_IDLE`, `ARB_BUSY`
  - port ids `PORT_IF` = 0, `PORT_D` = 1
  - `MEM_LATENCY` legality bounds
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from (`req[1:0]`, `last_winner`) to a one-hot grant. The `last_winner` register lives in the parent.

## Test plan
All scenarios use `MEM_LATENCY` = 2.
- Reset: `reset_n` low 3 cycles with both requests high → all outputs 0 throughout. First cycle after release → `if_gnt` = 1, `mem_addr` = `if_addr`.
- Lone fetch at 0x0000_0040, memory returns 0xDEAD_BEEF at T+2 → `if_rvalid` = 1 and `if_rdata` = 0xDEAD_BEEF at T+3; `d_gnt` and `d_rvalid` stay 0.
- Both requests held continuously from reset → grants alternate IF, D, IF, D at T, T+3, T+6, T+9; each `rvalid` lands on the matching port.
- Data write 0x0000_0100 ← 0x1234_5678 → at T: `mem_en` = 1, `mem_we` = 1, `mem_wdata` = 0x1234_5678. At T+3: `d_rvalid` = 1, `d_rdata` holds its previous value.
- `reset_n` pulsed low in cycle T+1 of a data read → no `d_rvalid` ever for it. After release with both requests high → fetch granted first.
- `d_req` raised at T+1 while fetch is in BUSY → `d_gnt` = 0 at T+1 and T+2; `d_gnt` = 1 at T+3, coincident with `if_rvalid`.
